qspi_target_responder: RTL and testbench

Quad-SPI target (flash-side) responder: the far end of the QSPI controller link, decoding quad-lane command/address frames from the controller and serving reads and writes against a byte-wide memory port. It oversamples the serial clock in the system clock domain and is used as the controller's loopback target in simulation and FPGA bring-up. SPI mode 0: sample on rising `sclk`, drive on falling `sclk`, MSB nibble first.

---
 rtl/qspi_resp_pkg.sv | 22 ++
 rtl/qspi_sync_edge.sv | 56 +++++
 rtl/qspi_target_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_qspi_target_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_resp_pkg.sv
// Shared types and constants for the quad-SPI target responder.
// Contents: FSM state enum, recognised command opcodes, frame field lengths in nibbles.
// Imported by qspi_target_responder.
package qspi_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h32;

    localparam int NIBBLES_CMD  = 2;
    localparam int NIBBLES_ADDR = 6;

endpackage

// File: rtl/qspi_sync_edge.sv
// Brings the asynchronous QSPI pins into the clk domain and derives edge pulses.
// Ports: sclk/cs_n/io_in raw pins in; io_s (synchronised lanes), sclk_rise/sclk_fall
//        (single-clk pulses, only while selected), cs_rise/cs_fall, cs_active (selected).
module qspi_sync_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [3:0] io_in,
    output logic [3:0] io_s,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       cs_rise,
    output logic       cs_fall,
    output logic       cs_active
);

    logic [1:0] sclk_ff;
    logic [1:0] cs_ff;
    logic [3:0] io_ff;
    logic       sclk_d;
    logic       cs_d;
    // Set once chip select has been seen high after reset. A reset that lands in the
    // middle of a frame must not treat the still-low cs_n as the start of a new frame,
    // so the cs_n synchroniser resets to "selected" and nothing is acted on until armed.
    logic       armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_ff <= 2'b00;
            cs_ff   <= 2'b00;
            io_ff   <= 4'h0;
            io_s    <= 4'h0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sclk_ff <= {sclk_ff[0], sclk};
            cs_ff   <= {cs_ff[0], cs_n};
            io_ff   <= io_in;
            io_s    <= io_ff;
            sclk_d  <= sclk_ff[1];
            cs_d    <= cs_ff[1];
            if (cs_ff[1]) begin
                armed <= 1'b1;
            end
        end
    end

    assign cs_active = armed & ~cs_ff[1];
    assign sclk_rise = cs_active & sclk_ff[1] & ~sclk_d;
    assign sclk_fall = cs_active & ~sclk_ff[1] & sclk_d;
    assign cs_fall   = armed & cs_d & ~cs_ff[1];
    assign cs_rise   = cs_ff[1] & ~cs_d;

endmodule

// File: rtl/qspi_target_responder.sv
// Quad-SPI target (flash side): decodes 0xEB quad read and, optionally, 0x32 quad write
// frames and serves them from a byte-wide memory port. Mode 0, MSB nibble first.
// Ports: clk/rst, sclk/cs_n/io_in from the controller, io_out/io_oe back to it,
//        mem_addr/mem_rd/mem_rdata/mem_wr/mem_wdata memory port, busy while selected.
// Build option: define QSPI_RESP_WRITE_EN to decode 0x32 and enable the write path.
module qspi_target_responder
    import qspi_resp_pkg::*;
#(
    parameter int DUMMY_CYCLES = 6,
    parameter int ADDR_W       = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    output logic              busy
);

    logic [3:0] io_s;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_rise;
    logic       cs_fall;
    logic       cs_active;

    qspi_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .io_in     (io_in),
        .io_s      (io_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .cs_active (cs_active)
    );

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;       // nibble / dummy-cycle counter, cleared on every state change
    logic [ADDR_W-1:0] sh;        // nibble shift register for command and address
    logic [ADDR_W-1:0] addr;      // running byte address of the frame
    logic [7:0]        rbyte;     // byte fetched from memory, waiting to be shifted out
    logic              rd_pend;   // mem_rdata is valid this cycle
    logic              lo;        // next data nibble is the low nibble

    logic [7:0]        cmd_byte;
    logic              last_cmd;
    logic              last_addr;
    logic              last_dummy;

    assign cmd_byte   = {sh[3:0], io_s};
    assign last_cmd   = sclk_rise && (cnt == 4'(NIBBLES_CMD - 1));
    assign last_addr  = sclk_rise && (cnt == 4'(NIBBLES_ADDR - 1));
    assign last_dummy = sclk_rise && (cnt == 4'(DUMMY_CYCLES - 1));

    assign busy  = cs_active;
    assign io_oe = (state == ST_RDATA) ? 4'hF : 4'h0;

`ifdef QSPI_RESP_WRITE_EN
    logic       is_wr;
    logic [3:0] wr_hi;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_nxt = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (last_cmd) begin
                        if (cmd_byte == CMD_QREAD) begin
                            state_nxt = ST_ADDR;
`ifdef QSPI_RESP_WRITE_EN
                        end else if (cmd_byte == CMD_QWRITE) begin
                            state_nxt = ST_ADDR;
`endif
                        end else begin
                            state_nxt = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (last_addr) begin
`ifdef QSPI_RESP_WRITE_EN
                        state_nxt = is_wr ? ST_WDATA : ST_DUMMY;
`else
                        state_nxt = ST_DUMMY;
`endif
                    end
                end
                ST_DUMMY: begin
                    if (last_dummy) begin
                        state_nxt = ST_RDATA;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'h0;
            sh       <= '0;
            addr     <= '0;
            rbyte    <= 8'h00;
            rd_pend  <= 1'b0;
            lo       <= 1'b0;
            io_out   <= 4'h0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
        end else begin
            mem_rd  <= 1'b0;
            rd_pend <= mem_rd;
            if (rd_pend) begin
                rbyte <= mem_rdata;
            end

            if (state_nxt != state) begin
                cnt <= 4'h0;
                lo  <= 1'b0;
            end else if (sclk_rise &&
                         (state == ST_CMD || state == ST_ADDR || state == ST_DUMMY)) begin
                cnt <= cnt + 4'd1;
            end

            if (sclk_rise && (state == ST_CMD || state == ST_ADDR)) begin
                sh <= {sh[ADDR_W-5:0], io_s};
            end

            if (state == ST_ADDR && last_addr) begin
                addr <= {sh[ADDR_W-5:0], io_s};
            end

            if (state == ST_DUMMY && last_dummy) begin
                mem_addr <= addr;
                mem_rd   <= 1'b1;
            end

            // Once the low nibble is on the lanes the current byte is finished, so the
            // next one is prefetched a full sclk period ahead of its first nibble.
            if (state == ST_RDATA && sclk_fall) begin
                if (!lo) begin
                    io_out <= rbyte[7:4];
                    lo     <= 1'b1;
                end else begin
                    io_out   <= rbyte[3:0];
                    lo       <= 1'b0;
                    addr     <= addr + ADDR_W'(1);
                    mem_addr <= addr + ADDR_W'(1);
                    mem_rd   <= 1'b1;
                end
            end

`ifdef QSPI_RESP_WRITE_EN
            if (state == ST_WDATA && sclk_rise) begin
                if (!lo) begin
                    lo <= 1'b1;
                end else begin
                    lo       <= 1'b0;
                    mem_addr <= addr;
                    addr     <= addr + ADDR_W'(1);
                end
            end
`endif
        end
    end

`ifdef QSPI_RESP_WRITE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_wr     <= 1'b0;
            wr_hi     <= 4'h0;
            mem_wr    <= 1'b0;
            mem_wdata <= 8'h00;
        end else begin
            mem_wr <= 1'b0;
            if (state == ST_CMD && last_cmd) begin
                is_wr <= (cmd_byte == CMD_QWRITE);
            end
            if (state == ST_WDATA && sclk_rise) begin
                if (!lo) begin
                    wr_hi <= io_s;
                end else begin
                    mem_wdata <= {wr_hi, io_s};
                    mem_wr    <= 1'b1;
                end
            end
        end
    end
`else
    assign mem_wr    = 1'b0;
    assign mem_wdata = 8'h00;
`endif

endmodule

// File: tb/tb_qspi_target_responder.sv
// Directed bench for qspi_target_responder: acts as the QSPI controller and as a
// one-cycle-latency memory returning {4'hA, addr[3:0]} for every read.
module tb_qspi_target_responder;

    localparam int DUMMY = 6;
    localparam int HALF  = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic [3:0]  io_in = 4'h0;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [23:0] rd_log[$];
    logic [23:0] wa_log[$];
    logic [7:0]  wd_log[$];
    logic        oe_seen = 1'b0;
    logic        rdwr_seen = 1'b0;

    qspi_target_responder #(.DUMMY_CYCLES(DUMMY), .ADDR_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= {4'hA, mem_addr[3:0]};
    end

    always @(negedge clk) begin
        if (mem_rd) rd_log.push_back(mem_addr);
        if (mem_wr) begin
            wa_log.push_back(mem_addr);
            wd_log.push_back(mem_wdata);
        end
        if (io_oe !== 4'h0) oe_seen = 1'b1;
        if (mem_rd && mem_wr) rdwr_seen = 1'b1;
    end

    task automatic clear_logs();
        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
        oe_seen = 1'b0;
        rdwr_seen = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] n);
        io_in = n;
        #HALF sclk = 1'b1;
        #HALF sclk = 1'b0;
    endtask

    task automatic get_nib(output logic [3:0] n);
        #HALF sclk = 1'b1;
        n = io_out;
        #HALF sclk = 1'b0;
    endtask

    task automatic select();
        @(negedge clk);
        #2 cs_n = 1'b0;
        #100;
    endtask

    task automatic start_frame(input logic [7:0] cmd, input logic [23:0] a);
        select();
        send_nib(cmd[7:4]);
        send_nib(cmd[3:0]);
        for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
    endtask

    task automatic end_frame();
        #HALF cs_n = 1'b1;
        #200;
    endtask

    task automatic test_reset();
        #23;
        total++; if (io_out !== 4'h0) begin bad++; $display("FAIL reset_io_out got=%h want=0", io_out); end
        total++; if (io_oe !== 4'h0) begin bad++; $display("FAIL reset_io_oe got=%h want=0", io_oe); end
        total++; if (mem_addr !== 24'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b want=0", mem_rd); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b want=0", mem_wr); end
        total++; if (mem_wdata !== 8'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        #100;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_read();
        logic [3:0] n;
        logic [3:0] exp;
        clear_logs();
        start_frame(8'hEB, 24'h000010);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy got=%b want=1", busy); end
        repeat (DUMMY) send_nib(4'h0);
        for (int i = 0; i < 8; i++) begin
            get_nib(n);
            exp = (i % 2 == 0) ? 4'hA : 4'(i / 2);
            total++; if (n !== exp) begin bad++; $display("FAIL read_nibble%0d got=%h want=%h", i, n, exp); end
            if (i == 0) begin
                total++; if (io_oe !== 4'hF) begin bad++; $display("FAIL read_io_oe got=%h want=f", io_oe); end
            end
        end
        end_frame();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_end got=%b want=0", busy); end
        total++; if (io_oe !== 4'h0) begin bad++; $display("FAIL read_oe_end got=%h want=0", io_oe); end
        total++;
        if (rd_log.size() < 4) begin
            bad++; $display("FAIL read_rd_count got=%0d want>=4", rd_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (rd_log[i] !== 24'h10 + 24'(i)) begin
                    bad++; $display("FAIL read_rd_addr%0d got=%h want=%h", i, rd_log[i], 24'h10 + 24'(i));
                end
            end
        end
        total++; if (wa_log.size() != 0) begin bad++; $display("FAIL read_no_wr got=%0d want=0", wa_log.size()); end
    endtask

    task automatic test_write();
        clear_logs();
        start_frame(8'h32, 24'h0000FF);
        send_nib(4'h5); send_nib(4'hA);
        send_nib(4'hC); send_nib(4'h3);
        end_frame();
`ifdef QSPI_RESP_WRITE_EN
        total++;
        if (wa_log.size() != 2) begin
            bad++; $display("FAIL write_count got=%0d want=2", wa_log.size());
        end else begin
            total++; if (wa_log[0] !== 24'h0000FF) begin bad++; $display("FAIL write_addr0 got=%h want=0000ff", wa_log[0]); end
            total++; if (wd_log[0] !== 8'h5A) begin bad++; $display("FAIL write_data0 got=%h want=5a", wd_log[0]); end
            total++; if (wa_log[1] !== 24'h000100) begin bad++; $display("FAIL write_addr1 got=%h want=000100", wa_log[1]); end
            total++; if (wd_log[1] !== 8'hC3) begin bad++; $display("FAIL write_data1 got=%h want=c3", wd_log[1]); end
        end
`else
        total++; if (wa_log.size() != 0) begin bad++; $display("FAIL write_disabled_count got=%0d want=0", wa_log.size()); end
        total++; if (mem_wdata !== 8'h00) begin bad++; $display("FAIL write_disabled_wdata got=%h want=0", mem_wdata); end
`endif
        total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL write_oe got=%b want=0", oe_seen); end
        total++; if (rd_log.size() != 0) begin bad++; $display("FAIL write_no_rd got=%0d want=0", rd_log.size()); end
    endtask

    task automatic test_unknown();
        logic [3:0] junk [10];
        junk = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h3, 4'h2, 4'hF};
        clear_logs();
        select();
        send_nib(4'h9); send_nib(4'hF);
        for (int i = 0; i < 10; i++) send_nib(junk[i]);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL unknown_busy got=%b want=1", busy); end
        end_frame();
        total++; if (rd_log.size() != 0) begin bad++; $display("FAIL unknown_rd got=%0d want=0", rd_log.size()); end
        total++; if (wa_log.size() != 0) begin bad++; $display("FAIL unknown_wr got=%0d want=0", wa_log.size()); end
        total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL unknown_oe got=%b want=0", oe_seen); end
    endtask

    task automatic test_wrap();
        logic [3:0] n;
        logic [3:0] exp [4];
        exp = '{4'hA, 4'hF, 4'hA, 4'h0};
        clear_logs();
        start_frame(8'hEB, 24'hFFFFFF);
        repeat (DUMMY) send_nib(4'h0);
        for (int i = 0; i < 4; i++) begin
            get_nib(n);
            total++; if (n !== exp[i]) begin bad++; $display("FAIL wrap_nibble%0d got=%h want=%h", i, n, exp[i]); end
        end
        end_frame();
        total++;
        if (rd_log.size() < 2) begin
            bad++; $display("FAIL wrap_rd_count got=%0d want>=2", rd_log.size());
        end else begin
            total++; if (rd_log[0] !== 24'hFFFFFF) begin bad++; $display("FAIL wrap_addr0 got=%h want=ffffff", rd_log[0]); end
            total++; if (rd_log[1] !== 24'h000000) begin bad++; $display("FAIL wrap_addr1 got=%h want=000000", rd_log[1]); end
        end
    endtask

    task automatic test_partial_write();
        logic [3:0] hi;
        logic [3:0] lo_n;
        clear_logs();
        start_frame(8'h32, 24'h000040);
        send_nib(4'h7);
        end_frame();
        total++; if (wa_log.size() != 0) begin bad++; $display("FAIL partial_wr got=%0d want=0", wa_log.size()); end
        clear_logs();
        start_frame(8'hEB, 24'h000025);
        repeat (DUMMY) send_nib(4'h0);
        get_nib(hi);
        get_nib(lo_n);
        end_frame();
        total++; if (hi !== 4'hA) begin bad++; $display("FAIL partial_next_hi got=%h want=a", hi); end
        total++; if (lo_n !== 4'h5) begin bad++; $display("FAIL partial_next_lo got=%h want=5", lo_n); end
        total++;
        if (rd_log.size() < 1 || rd_log[0] !== 24'h000025) begin
            bad++; $display("FAIL partial_next_addr got=%h want=000025", (rd_log.size() > 0) ? rd_log[0] : 24'hx);
        end
    endtask

    task automatic test_rst_mid();
        logic [3:0] n;
        logic [3:0] hi;
        logic [3:0] lo_n;
        clear_logs();
        start_frame(8'hEB, 24'h000030);
        repeat (DUMMY) send_nib(4'h0);
        get_nib(n);
        get_nib(n);
        get_nib(n);
        #60;
        rst = 1'b1;
        #1;
        total++; if (io_out !== 4'h0) begin bad++; $display("FAIL rst_mid_io_out got=%h want=0", io_out); end
        total++; if (io_oe !== 4'h0) begin bad++; $display("FAIL rst_mid_io_oe got=%h want=0", io_oe); end
        total++; if (mem_addr !== 24'h0) begin bad++; $display("FAIL rst_mid_mem_addr got=%h want=0", mem_addr); end
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL rst_mid_mem_rd got=%b want=0", mem_rd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        #10 rst = 1'b0;
        clear_logs();
        send_nib(4'hE); send_nib(4'hB);
        for (int i = 0; i < 6; i++) send_nib(4'h0);
        total++; if (rd_log.size() != 0) begin bad++; $display("FAIL rst_mid_rd got=%0d want=0", rd_log.size()); end
        total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL rst_mid_oe got=%b want=0", oe_seen); end
        end_frame();
        clear_logs();
        start_frame(8'hEB, 24'h00003C);
        repeat (DUMMY) send_nib(4'h0);
        get_nib(hi);
        get_nib(lo_n);
        end_frame();
        total++; if (hi !== 4'hA) begin bad++; $display("FAIL rst_fresh_hi got=%h want=a", hi); end
        total++; if (lo_n !== 4'hC) begin bad++; $display("FAIL rst_fresh_lo got=%h want=c", lo_n); end
        total++;
        if (rd_log.size() < 1 || rd_log[0] !== 24'h00003C) begin
            bad++; $display("FAIL rst_fresh_addr got=%h want=00003c", (rd_log.size() > 0) ? rd_log[0] : 24'hx);
        end
    endtask

    task automatic test_no_rd_wr_overlap();
        total++; if (rdwr_seen !== 1'b0) begin bad++; $display("FAIL rd_wr_overlap got=%b want=0", rdwr_seen); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_no_rd_wr_overlap();
        test_unknown();
        test_wrap();
        test_partial_write();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
